// File: rtl/i2c_reg_responder.sv
// i2c_reg_responder: register-bus target behind the I2C sequencer.
// Commits writes into a bank of 8-bit control registers. Serves reads as a
// byte stream to the I2C transmitter, one byte for each rising edge of tx_byte_req.
// Optional feature: define I2C_RESP_AUTOINC_EN so that the read pointer
// auto-increments between streamed bytes. When it is undefined, every streamed
// byte re-reads the addressed register.
module i2c_reg_responder #(
  parameter logic [10:0] ADDR_BASE = 11'h000,
  parameter int unsigned NUM_REGS  = 16
) (
  input  logic                  Clock,
  input  logic                  reset,
  input  logic                  i2c_op,
  input  logic [10:0]           i2c_addr,
  input  logic [7:0]            i2c_data,
  input  logic                  i2c_xfc,
  input  logic                  tx_byte_req,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  output logic                  xfc_err,
  output logic                  busy,
  output logic [NUM_REGS*8-1:0] reg_out
);

  localparam int unsigned IDX_W   = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [11:0] BASE_12 = {1'b0, ADDR_BASE};
  localparam logic [11:0] END_12  = BASE_12 + 12'(NUM_REGS);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR,
    ST_RD_LOAD,
    ST_RD_PRESENT,
    ST_RD_STREAM
  } state_t;

  state_t           state_q, state_d;
  logic [10:0]      addr_q, addr_d;
  logic [7:0]       wdata_q, wdata_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic             oor_q, oor_d;
  logic [7:0]       tx_data_d;
  logic             tx_valid_d, xfc_err_d, busy_d;
  logic             req_q, req_edge_q;
  logic             wr_en;
  logic [7:0]       regs_q [NUM_REGS];

  logic [11:0]      addr_ext;
  logic             addr_in_range;
  logic [IDX_W-1:0] addr_idx;

  // Range check and index of the latched address, done in 12 bits so base+size cannot overflow
  always_comb begin
    addr_ext      = {1'b0, addr_q};
    addr_in_range = (addr_ext >= BASE_12) && (addr_ext < END_12);
    addr_idx      = IDX_W'(addr_ext - BASE_12);
  end

  // Next-state and next-output logic
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    ptr_d      = ptr_q;
    oor_d      = oor_q;
    tx_data_d  = tx_data;
    tx_valid_d = 1'b0;
    xfc_err_d  = 1'b0;
    wr_en      = 1'b0;

    unique case (state_q)
      ST_IDLE, ST_RD_STREAM: begin
        // A new transfer ends any stream; it takes priority over a pending request edge
        if (i2c_xfc) begin
          addr_d  = i2c_addr;
          wdata_d = i2c_data;
          state_d = i2c_op ? ST_WR : ST_RD_LOAD;
        end else if ((state_q == ST_RD_STREAM) && req_edge_q) begin
          state_d = ST_RD_PRESENT;
        end
      end
      ST_WR: begin
        if (addr_in_range) wr_en = 1'b1;
        xfc_err_d = !addr_in_range || i2c_xfc;
        state_d   = ST_IDLE;
      end
      ST_RD_LOAD: begin
        ptr_d     = addr_idx;
        oor_d     = !addr_in_range;
        xfc_err_d = i2c_xfc;
        state_d   = ST_RD_PRESENT;
      end
      ST_RD_PRESENT: begin
        tx_data_d  = oor_q ? 8'hFF : regs_q[ptr_q];
        tx_valid_d = 1'b1;
        xfc_err_d  = oor_q || i2c_xfc;
`ifdef I2C_RESP_AUTOINC_EN
        ptr_d      = ptr_q + IDX_W'(1);
`endif
        state_d    = ST_RD_STREAM;
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d == ST_WR) || (state_d == ST_RD_LOAD) || (state_d == ST_RD_PRESENT);
  end

  // State, control and output registers
  always_ff @(posedge Clock) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      ptr_q      <= '0;
      oor_q      <= 1'b0;
      tx_data    <= 8'h00;
      tx_valid   <= 1'b0;
      xfc_err    <= 1'b0;
      busy       <= 1'b0;
      req_q      <= 1'b0;
      req_edge_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      ptr_q      <= ptr_d;
      oor_q      <= oor_d;
      tx_data    <= tx_data_d;
      tx_valid   <= tx_valid_d;
      xfc_err    <= xfc_err_d;
      busy       <= busy_d;
      req_q      <= tx_byte_req;
      req_edge_q <= tx_byte_req && !req_q;
    end
  end

  // Register bank
  always_ff @(posedge Clock) begin
    if (reset) begin
      for (int i = 0; i < int'(NUM_REGS); i++) regs_q[i] <= 8'h00;
    end else if (wr_en) begin
      regs_q[addr_idx] <= wdata_q;
    end
  end

  // Flatten the bank for the control logic
  always_comb begin
    for (int i = 0; i < int'(NUM_REGS); i++) reg_out[8*i +: 8] = regs_q[i];
  end

endmodule

// File: tb/tb_i2c_reg_responder.sv
// Bench for i2c_reg_responder: directed steps followed by random transfers.
// Each transfer is checked against an array model of the register bank.
module tb_i2c_reg_responder;

  localparam logic [10:0] BASE = 11'h010;
  localparam int          N    = 16;
  localparam int          BI   = 16;

`ifdef I2C_RESP_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif

  logic         Clock = 1'b0;
  logic         reset;
  logic         i2c_op;
  logic [10:0]  i2c_addr;
  logic [7:0]   i2c_data;
  logic         i2c_xfc;
  logic         tx_byte_req;
  logic [7:0]   tx_data;
  logic         tx_valid;
  logic         xfc_err;
  logic         busy;
  logic [N*8-1:0] reg_out;

  i2c_reg_responder #(.ADDR_BASE(BASE), .NUM_REGS(N)) dut (
    .Clock(Clock), .reset(reset), .i2c_op(i2c_op), .i2c_addr(i2c_addr),
    .i2c_data(i2c_data), .i2c_xfc(i2c_xfc), .tx_byte_req(tx_byte_req),
    .tx_data(tx_data), .tx_valid(tx_valid), .xfc_err(xfc_err), .busy(busy),
    .reg_out(reg_out)
  );

  always #5 Clock = ~Clock;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] model [N];
  int  rd_idx;
  bit  rd_oor;
  int  rd_count;

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [127:0] model_flat();
    logic [127:0] f = '0;
    for (int i = 0; i < N; i++) f[8*i +: 8] = model[i];
    return f;
  endfunction

  function automatic bit in_range(input int a);
    return (a >= BI) && (a < BI + N);
  endfunction

  function automatic logic [7:0] expected_byte();
    if (rd_oor) return 8'hFF;
    return model[(rd_idx + (AUTOINC ? rd_count : 0)) % N];
  endfunction

  task automatic do_write(input int a, input logic [7:0] d);
    i2c_op = 1'b1; i2c_addr = 11'(a); i2c_data = d; i2c_xfc = 1'b1;
    step();
    i2c_xfc = 1'b0;
    check("wr_busy", 128'(busy), 128'(1'b1));
    step();
    if (in_range(a)) model[a - BI] = d;
    check("wr_regs", 128'(reg_out), model_flat());
    check("wr_err", 128'(xfc_err), 128'(!in_range(a)));
    check("wr_busy_done", 128'(busy), 128'(1'b0));
  endtask

  task automatic do_read(input int a);
    i2c_op = 1'b0; i2c_addr = 11'(a); i2c_data = 8'h00; i2c_xfc = 1'b1;
    step();
    i2c_xfc = 1'b0;
    rd_oor = !in_range(a); rd_idx = a - BI; rd_count = 0;
    step();
    check("rd_early_valid", 128'(tx_valid), 128'(1'b0));
    step();
    check("rd_valid", 128'(tx_valid), 128'(1'b1));
    check("rd_data", 128'(tx_data), 128'(expected_byte()));
    check("rd_err", 128'(xfc_err), 128'(rd_oor));
  endtask

  task automatic stream_next();
    logic [7:0] prev;
    prev = tx_data;
    tx_byte_req = 1'b1;
    step();
    tx_byte_req = 1'b0;
    check("st_hold", 128'(tx_data), 128'(prev));
    step();
    check("st_early_valid", 128'(tx_valid), 128'(1'b0));
    step();
    rd_count++;
    check("st_valid", 128'(tx_valid), 128'(1'b1));
    check("st_data", 128'(tx_data), 128'(expected_byte()));
    check("st_err", 128'(xfc_err), 128'(rd_oor));
  endtask

  initial begin
    int a;
    int nrd;
    reset = 1'b1; i2c_op = 1'b0; i2c_addr = '0; i2c_data = '0;
    i2c_xfc = 1'b0; tx_byte_req = 1'b0;
    for (int i = 0; i < N; i++) model[i] = 8'h00;
    step(); step();
    reset = 1'b0;
    step();
    check("rst_regs", 128'(reg_out), 128'(0));
    check("rst_txd", 128'(tx_data), 128'(0));
    check("rst_valid", 128'(tx_valid), 128'(0));
    check("rst_err", 128'(xfc_err), 128'(0));
    check("rst_busy", 128'(busy), 128'(0));

    // Single write to register 3
    do_write(BI + 3, 8'hA5);
    check("wr_byte3", 128'(reg_out[31:24]), 128'(8'hA5));

    // Preload and stream across the wrap point
    for (int i = 0; i < N; i++) do_write(BI + i, 8'(8'h10 + i));
    do_read(BI + 14);
    check("rd14_const", 128'(tx_data), 128'(8'h1E));
    for (int k = 0; k < 3; k++) stream_next();
    check("rd_last_const", 128'(tx_data), 128'(AUTOINC ? 8'h11 : 8'h1E));

    // Out-of-range read, then out-of-range write just below the base
    do_read(BI + N);
    stream_next();
    do_write(BI - 1, 8'h3C);

    // Second strobe one cycle after a read strobe is dropped
    i2c_op = 1'b0; i2c_addr = 11'(BI + 5); i2c_xfc = 1'b1;
    step();
    i2c_op = 1'b1; i2c_addr = 11'(BI); i2c_data = 8'h77;
    step();
    i2c_xfc = 1'b0;
    check("drop_err", 128'(xfc_err), 128'(1'b1));
    check("drop_novalid", 128'(tx_valid), 128'(1'b0));
    step();
    rd_oor = 1'b0; rd_idx = 5; rd_count = 0;
    check("drop_rd_valid", 128'(tx_valid), 128'(1'b1));
    check("drop_rd_data", 128'(tx_data), 128'(expected_byte()));
    check("drop_rd_err", 128'(xfc_err), 128'(1'b0));
    check("drop_regs", 128'(reg_out), model_flat());

    // Write strobe coinciding with a request edge in the stream
    tx_byte_req = 1'b1;
    step();
    tx_byte_req = 1'b0;
    i2c_op = 1'b1; i2c_addr = 11'(BI + 2); i2c_data = 8'h5A; i2c_xfc = 1'b1;
    step();
    i2c_xfc = 1'b0;
    check("coll_novalid0", 128'(tx_valid), 128'(1'b0));
    step();
    model[2] = 8'h5A;
    check("coll_novalid1", 128'(tx_valid), 128'(1'b0));
    check("coll_regs", 128'(reg_out), model_flat());
    tx_byte_req = 1'b1;
    step();
    tx_byte_req = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      check("idle_req_ignored", 128'(tx_valid), 128'(1'b0));
    end
    check("idle_busy", 128'(busy), 128'(1'b0));

    // Reset in the middle of a stream
    do_read(BI + 1);
    stream_next();
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tx_byte_req = ~tx_byte_req;
      step();
    end
    for (int i = 0; i < N; i++) model[i] = 8'h00;
    check("mid_rst_regs", 128'(reg_out), 128'(0));
    check("mid_rst_txd", 128'(tx_data), 128'(0));
    check("mid_rst_valid", 128'(tx_valid), 128'(0));
    check("mid_rst_busy", 128'(busy), 128'(0));
    reset = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tx_byte_req = ~tx_byte_req;
      step();
      check("post_rst_valid", 128'(tx_valid), 128'(1'b0));
    end
    tx_byte_req = 1'b0;
    step();

    // Random transfers around the window boundaries
    for (int t = 0; t < 60; t++) begin
      a = int'($urandom_range(BI + N + 2, BI - 3));
      if ($urandom_range(1, 0) == 1) begin
        do_write(a, 8'($urandom));
      end else begin
        do_read(a);
        nrd = int'($urandom_range(3, 0));
        for (int k = 0; k < nrd; k++) stream_next();
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
